fwd_hazard_tracker: RTL and testbench

- Parametrised forwarding and hazard unit for the pipelined RISC-V core; successor to the fixed two-operand, fixed-stage forwarding logic.
- Keeps a registered shift-tracker of in-flight destination writes, one entry per stage after ID (entry 1 = EX, 2 = MEM, 3 = WB, ...).
- For every source operand of the instruction in ID, picks the youngest in-flight producer: either a forward select, or a stall when that producer's data is not yet available.
- Inserts bubbles on stall and counts stall cycles for performance monitoring.

---
 rtl/fwd_hazard_tracker.sv | 106 ++++++++++
 tb/tb_fwd_hazard_tracker.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_tracker.sv
// Forwarding / hazard unit: tracks in-flight destination writes per stage after ID
// and resolves each ID source operand to a forward select or a stall.
module fwd_hazard_tracker #(
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned DEPTH      = 3,
    parameter int unsigned NUM_SRC    = 2,
    parameter int unsigned ALU_READY  = 1,
    parameter int unsigned LOAD_READY = 2,
    parameter int unsigned SEL_W      = $clog2(DEPTH + 1),
    parameter int unsigned CNT_W      = 32
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      issue_valid,
    input  logic [REG_AW-1:0]         issue_rd,
    input  logic                      issue_regwrite,
    input  logic                      issue_is_load,
    input  logic [NUM_SRC-1:0]        src_valid,
    input  logic [NUM_SRC*REG_AW-1:0] src_addr,
    input  logic                      pipe_hold,
    input  logic                      flush,
    output logic                      stall,
    output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
    output logic [CNT_W-1:0]          stall_count
);

    localparam int ALU_RDY  = int'(ALU_READY);
    localparam int LOAD_RDY = int'(LOAD_READY);

    typedef struct packed {
        logic              valid;
        logic              is_load;
        logic [REG_AW-1:0] rd;
    } entry_t;

    entry_t [DEPTH:1]   trk_q, trk_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_SRC-1:0] src_stall_c;
    logic [REG_AW-1:0]  addr_c;
    entry_t             new_ent_c;

    // Youngest producer wins: scan oldest to youngest so the smallest stage overrides.
    always_comb begin
        fwd_sel     = '0;
        src_stall_c = '0;
        addr_c      = '0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            addr_c = src_addr[i*REG_AW +: REG_AW];
            for (int k = int'(DEPTH); k >= 1; k--) begin
                if (src_valid[i] && (addr_c != '0) && trk_q[k].valid && (trk_q[k].rd == addr_c)) begin
                    if (k >= (trk_q[k].is_load ? LOAD_RDY : ALU_RDY)) begin
                        fwd_sel[i*SEL_W +: SEL_W] = SEL_W'(k);
                        src_stall_c[i]            = 1'b0;
                    end else begin
                        fwd_sel[i*SEL_W +: SEL_W] = '0;
                        src_stall_c[i]            = 1'b1;
                    end
                end
            end
        end
    end

    assign stall = |src_stall_c;

    // Tracker next state: shift, hold, or squash the EX slot on flush.
    always_comb begin
        trk_d             = trk_q;
        new_ent_c.valid   = issue_valid && !stall && issue_regwrite && (issue_rd != '0);
        new_ent_c.is_load = issue_is_load;
        new_ent_c.rd      = issue_rd;
        if (flush) begin
            trk_d[1] = '0;
            if (!pipe_hold) begin
                for (int k = 2; k <= int'(DEPTH); k++) begin
                    trk_d[k] = (k == 2) ? entry_t'('0) : trk_q[k-1];
                end
            end
        end else if (!pipe_hold) begin
            for (int k = 2; k <= int'(DEPTH); k++) begin
                trk_d[k] = trk_q[k-1];
            end
            trk_d[1] = new_ent_c.valid ? new_ent_c : entry_t'('0);
        end
    end

    // Saturating stall-cycle counter.
    always_comb begin
        cnt_d = cnt_q;
        if (stall && !pipe_hold && !flush && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            trk_q <= '0;
            cnt_q <= '0;
        end else begin
            trk_q <= trk_d;
            cnt_q <= cnt_d;
        end
    end

    assign stall_count = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_tracker.sv
// Bench for fwd_hazard_tracker: directed vector table, hand-written corner sequences
// and randomized traffic against a queue-based reference model.
module tb_fwd_hazard_tracker;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset_n;

    // default configuration instance
    logic        a_iv, a_rw, a_ld, a_hold, a_flush, a_stall;
    logic [4:0]  a_rd;
    logic [1:0]  a_sv;
    logic [9:0]  a_sa;
    logic [3:0]  a_sel;
    logic [31:0] a_cnt;

    // wider configuration instance
    logic        b_iv, b_rw, b_ld, b_hold, b_flush, b_stall;
    logic [4:0]  b_rd;
    logic [2:0]  b_sv;
    logic [14:0] b_sa;
    logic [8:0]  b_sel;
    logic [31:0] b_cnt;

    fwd_hazard_tracker dut_a (
        .clk(clk), .reset_n(reset_n), .issue_valid(a_iv), .issue_rd(a_rd),
        .issue_regwrite(a_rw), .issue_is_load(a_ld), .src_valid(a_sv), .src_addr(a_sa),
        .pipe_hold(a_hold), .flush(a_flush), .stall(a_stall), .fwd_sel(a_sel),
        .stall_count(a_cnt)
    );

    fwd_hazard_tracker #(.NUM_SRC(3), .DEPTH(5), .LOAD_READY(3)) dut_b (
        .clk(clk), .reset_n(reset_n), .issue_valid(b_iv), .issue_rd(b_rd),
        .issue_regwrite(b_rw), .issue_is_load(b_ld), .src_valid(b_sv), .src_addr(b_sa),
        .pipe_hold(b_hold), .flush(b_flush), .stall(b_stall), .fwd_sel(b_sel),
        .stall_count(b_cnt)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        bit       iv;
        bit [4:0] rd;
        bit       rw;
        bit       ld;
        bit [1:0] sv;
        bit [4:0] a0;
        bit [4:0] a1;
        bit       hold;
        bit       flush;
        bit       e_stall;
        bit [1:0] e_s0;
        bit [1:0] e_s1;
        int       e_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(bit iv, bit [4:0] rd, bit rw, bit ld, bit [1:0] sv,
                               bit [4:0] a0, bit [4:0] a1, bit hold, bit flush,
                               bit es, bit [1:0] s0, bit [1:0] s1, int cnt);
        vec_t r;
        r.iv = iv; r.rd = rd; r.rw = rw; r.ld = ld; r.sv = sv; r.a0 = a0; r.a1 = a1;
        r.hold = hold; r.flush = flush; r.e_stall = es; r.e_s0 = s0; r.e_s1 = s1; r.e_cnt = cnt;
        return r;
    endfunction

    // Reference model: queue of in-flight writes, index 0 = youngest (stage 1).
    typedef struct {
        bit       v;
        bit       ld;
        bit [4:0] rd;
    } ment_t;

    ment_t       mp[$];
    logic [31:0] m_cnt;

    function automatic void m_reset();
        mp.delete();
        repeat (3) mp.push_back('{v: 1'b0, ld: 1'b0, rd: 5'd0});
        m_cnt = '0;
    endfunction

    function automatic void m_eval(output bit st, output bit [3:0] sel);
        bit [4:0] addr;
        int       need;
        st  = 1'b0;
        sel = '0;
        for (int i = 0; i < 2; i++) begin
            addr = a_sa[i*5 +: 5];
            if (a_sv[i] && addr != 5'd0) begin
                for (int k = 0; k < mp.size(); k++) begin
                    if (mp[k].v && mp[k].rd == addr) begin
                        need = mp[k].ld ? 2 : 1;
                        if (k + 1 >= need) sel[i*2 +: 2] = 2'(k + 1);
                        else st = 1'b1;
                        break;
                    end
                end
            end
        end
    endfunction

    function automatic void m_step(bit st);
        ment_t nw, bub;
        bub = '{v: 1'b0, ld: 1'b0, rd: 5'd0};
        nw  = '{v: (a_rw && a_rd != 5'd0), ld: a_ld, rd: a_rd};
        if (a_flush) begin
            if (!a_hold) begin
                mp.push_front(bub);
                void'(mp.pop_back());
                mp[1] = bub;
            end else begin
                mp[0] = bub;
            end
        end else if (!a_hold) begin
            if (st && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
            mp.push_front((a_iv && !st) ? nw : bub);
            void'(mp.pop_back());
        end
    endfunction

    task automatic idle_inputs();
        a_iv = 0; a_rd = 0; a_rw = 0; a_ld = 0; a_sv = 0; a_sa = 0; a_hold = 0; a_flush = 0;
        b_iv = 0; b_rd = 0; b_rw = 0; b_ld = 0; b_sv = 0; b_sa = 0; b_hold = 0; b_flush = 0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        idle_inputs();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic a_issue(bit iv, bit [4:0] rd, bit rw, bit ld, bit [1:0] sv,
                           bit [4:0] a0, bit [4:0] a1);
        a_iv = iv; a_rd = rd; a_rw = rw; a_ld = ld; a_sv = sv; a_sa = {a1, a0};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit       ms;
        bit [3:0] msel;

        // Directed table: one row per cycle, starting from an empty tracker.
        vecs.push_back(v(1,5,1,0, 0,0,0, 0,0, 0,0,0, 0));
        vecs.push_back(v(1,0,0,0, 1,5,0, 0,0, 0,1,0, 0));
        vecs.push_back(v(1,0,0,0, 1,5,0, 0,0, 0,2,0, 0));
        vecs.push_back(v(1,0,0,0, 1,5,0, 0,0, 0,3,0, 0));
        vecs.push_back(v(1,0,0,0, 1,5,0, 0,0, 0,0,0, 0));
        vecs.push_back(v(1,7,1,1, 0,0,0, 0,0, 0,0,0, 0));
        vecs.push_back(v(1,9,1,0, 2,0,7, 0,0, 1,0,0, 0));
        vecs.push_back(v(1,9,1,0, 2,0,7, 0,0, 0,0,2, 1));
        vecs.push_back(v(1,3,1,0, 0,0,0, 0,0, 0,0,0, 1));
        vecs.push_back(v(1,3,1,0, 1,3,0, 0,0, 0,1,0, 1));
        vecs.push_back(v(1,3,1,1, 1,3,0, 0,0, 0,1,0, 1));
        vecs.push_back(v(1,0,0,0, 1,3,0, 0,0, 1,0,0, 1));
        vecs.push_back(v(1,0,0,0, 1,3,0, 0,0, 0,2,0, 2));
        vecs.push_back(v(1,0,1,0, 0,0,0, 0,0, 0,0,0, 2));
        vecs.push_back(v(1,0,0,0, 3,0,0, 0,0, 0,0,0, 2));
        vecs.push_back(v(1,4,1,0, 0,0,0, 0,0, 0,0,0, 2));
        vecs.push_back(v(1,0,0,0, 0,4,4, 0,0, 0,0,0, 2));
        vecs.push_back(v(1,0,0,0, 3,4,4, 0,0, 0,2,2, 2));
        vecs.push_back(v(1,7,1,1, 0,0,0, 0,0, 0,0,0, 2));
        vecs.push_back(v(1,0,0,0, 1,7,0, 0,1, 1,0,0, 2));
        vecs.push_back(v(1,0,0,0, 1,7,0, 0,0, 0,0,0, 2));
        vecs.push_back(v(1,6,1,0, 0,0,0, 0,0, 0,0,0, 2));
        vecs.push_back(v(1,0,0,0, 1,6,0, 1,1, 0,1,0, 2));
        vecs.push_back(v(1,0,0,0, 1,6,0, 0,0, 0,0,0, 2));

        reset_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        chk("reset stall", 64'(a_stall), 64'd0);
        chk("reset sel",   64'(a_sel),   64'd0);
        chk("reset cnt",   64'(a_cnt),   64'd0);
        reset_n = 1'b1;

        foreach (vecs[n]) begin
            a_iv = vecs[n].iv; a_rd = vecs[n].rd; a_rw = vecs[n].rw; a_ld = vecs[n].ld;
            a_sv = vecs[n].sv; a_sa = {vecs[n].a1, vecs[n].a0};
            a_hold = vecs[n].hold; a_flush = vecs[n].flush;
            #1;
            chk($sformatf("vec%0d stall", n), 64'(a_stall), 64'(vecs[n].e_stall));
            chk($sformatf("vec%0d sel", n),   64'(a_sel),   64'({vecs[n].e_s1, vecs[n].e_s0}));
            chk($sformatf("vec%0d cnt", n),   64'(a_cnt),   64'(vecs[n].e_cnt));
            tick();
        end

        // Hold during a load-use stall: outputs frozen, count unchanged.
        do_reset();
        a_issue(1, 7, 1, 1, 0, 0, 0);
        tick();
        a_issue(1, 0, 0, 0, 2, 0, 7);
        a_hold = 1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("hold%0d stall", c), 64'(a_stall), 64'd1);
            chk($sformatf("hold%0d sel", c),   64'(a_sel),   64'd0);
            chk($sformatf("hold%0d cnt", c),   64'(a_cnt),   64'd0);
            tick();
        end
        a_hold = 0;
        #1;
        chk("unhold stall", 64'(a_stall), 64'd1);
        tick();
        #1;
        chk("unhold fwd stall", 64'(a_stall), 64'd0);
        chk("unhold fwd sel",   64'(a_sel),   64'h8);
        chk("unhold fwd cnt",   64'(a_cnt),   64'd1);

        // Async reset between edges with three valid entries and stall asserted.
        do_reset();
        a_issue(1, 9, 1, 1, 0, 0, 0); tick();
        a_issue(1, 0, 0, 0, 1, 9, 0); tick();
        a_issue(1, 1, 1, 0, 0, 0, 0); tick();
        a_issue(1, 2, 1, 0, 0, 0, 0); tick();
        a_issue(1, 3, 1, 1, 0, 0, 0); tick();
        a_issue(1, 0, 0, 0, 1, 3, 0);
        #1;
        chk("pre-rst stall", 64'(a_stall), 64'd1);
        chk("pre-rst cnt",   64'(a_cnt),   64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async rst stall", 64'(a_stall), 64'd0);
        chk("async rst sel",   64'(a_sel),   64'd0);
        chk("async rst cnt",   64'(a_cnt),   64'd0);
        tick();
        reset_n = 1'b1;

        // Wider configuration: load stalls at stage 2, forwards from stage 3.
        do_reset();
        b_iv = 1; b_rd = 8; b_rw = 1; b_ld = 1; b_sv = 0; b_sa = 0;
        tick();
        b_rd = 0; b_rw = 0; b_ld = 0;
        tick();
        b_sv = 3'b100; b_sa = {5'd8, 10'd0};
        #1;
        chk("cfgB stage2 stall", 64'(b_stall), 64'd1);
        chk("cfgB stage2 sel",   64'(b_sel),   64'd0);
        tick();
        #1;
        chk("cfgB stage3 stall", 64'(b_stall), 64'd0);
        chk("cfgB stage3 sel",   64'(b_sel),   64'(9'b011_000_000));
        chk("cfgB cnt",          64'(b_cnt),   64'd1);

        // Randomized traffic against the reference model.
        do_reset();
        m_reset();
        for (int c = 0; c < 1500; c++) begin
            a_iv    = 1'($urandom_range(0, 1));
            a_rd    = 5'($urandom_range(0, 4));
            a_rw    = ($urandom_range(0, 3) != 0);
            a_ld    = ($urandom_range(0, 2) == 0);
            a_sv    = 2'($urandom_range(0, 3));
            a_sa    = {5'($urandom_range(0, 4)), 5'($urandom_range(0, 4))};
            a_hold  = ($urandom_range(0, 7) == 0);
            a_flush = ($urandom_range(0, 9) == 0);
            #1;
            m_eval(ms, msel);
            chk($sformatf("rnd%0d stall", c), 64'(a_stall), 64'(ms));
            chk($sformatf("rnd%0d sel", c),   64'(a_sel),   64'(msel));
            chk($sformatf("rnd%0d cnt", c),   64'(a_cnt),   64'(m_cnt));
            tick();
            m_step(ms);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
